wb_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave Wishbone B4 (classic) arbiter. It succeeds the fixed two-master instruction/data arbiter that sits in front of the RAM.
- Fair round-robin grant.
- Per-transfer slave timeout that answers a hung slave with err.
- Grant hand-over with no idle cycle between owners.
- Sits between the core's buses (plus future DMA/debug masters) and a shared slave such as ram_wb.

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 29 ++
 rtl/wb_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the round-robin Wishbone arbiter.
// Widths depend on module parameters, so they are derived through these functions.
package wb_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int MAX_IDX_W = idx_w(MAX_MASTERS);
  typedef logic [MAX_IDX_W-1:0] max_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester search: scans start, start+1, ... with wrap and returns
// the first active request, optionally skipping one excluded index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [IW-1:0] excl,
  input  logic          excl_en,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && req[j] && !(excl_en && (j == int'(excl)))) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter with round-robin grant,
// zero-gap hand-over and a per-transfer slave timeout that answers with err.
//
// state | meaning
// IDLE  | no owner; any m_cyc is arbitrated starting after the last owner
// OWNED | slave port mirrors owner; owner dropping cyc hands over in the same edge
import wb_arb_pkg::*;

module wb_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_cyc,
  input  logic [N_MASTERS-1:0]          m_stb,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dat_w,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_sel,
  output logic [DATA_W-1:0]             m_dat_r,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_err,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [DATA_W-1:0]             s_dat_w,
  output logic [DATA_W/8-1:0]           s_sel,
  input  logic [DATA_W-1:0]             s_dat_r,
  input  logic                          s_ack,
  input  logic                          s_err,
  output logic [N_MASTERS-1:0]          grant
);

  localparam int IW = idx_w(N_MASTERS);
  localparam int CW = cnt_w(TIMEOUT);
  localparam int SW = DATA_W / 8;
  localparam logic [IW-1:0] LAST_RST = IW'(N_MASTERS - 1);
  localparam logic [CW-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          owned;
  logic          stall;
  logic          timeout_hit;
  logic [IW-1:0] base;
  logic [IW-1:0] pick_start;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  int            own_i;

  assign owned = (state_q == OWNED);
  assign own_i = int'(owner_q);

  // Stall uses the owner's raw stb so forcing s_stb low cannot feed back.
  assign stall       = owned && m_cyc[owner_q] && m_stb[owner_q] && !s_ack && !s_err;
  assign timeout_hit = (TIMEOUT != 0) && stall && (cnt_q == TO_LAST);

  // Scan begins just after the current owner on hand-over, after last in IDLE.
  assign base       = owned ? owner_q : last_q;
  assign pick_start = (base == LAST_RST) ? '0 : base + 1'b1;

  rr_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_pick (
    .req     (m_cyc),
    .start   (pick_start),
    .excl    (owner_q),
    .excl_en (owned),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWNED;
          owner_d = pick_idx;
        end
      end
      OWNED: begin
        if (!m_cyc[owner_q]) begin
          last_d = owner_q;
          if (pick_found) owner_d = pick_idx;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (stall && !timeout_hit) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    m_ack   = '0;
    m_err   = '0;
    grant   = '0;
    if (owned) begin
      s_cyc          = m_cyc[owner_q];
      s_stb          = m_stb[owner_q] && !timeout_hit;
      s_we           = m_we[owner_q];
      s_adr          = m_adr[own_i*ADDR_W +: ADDR_W];
      s_dat_w        = m_dat_w[own_i*DATA_W +: DATA_W];
      s_sel          = m_sel[own_i*SW +: SW];
      m_ack[owner_q] = s_ack;
      m_err[owner_q] = s_err || timeout_hit;
      grant[owner_q] = 1'b1;
    end
  end

  assign m_dat_r = s_dat_r;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (4 masters, timeout of 4): a vector table
// stepped one cycle per row, plus hand sequences for timeout/ack race and reset.
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      m_cyc = '0, m_stb = '0, m_we = 4'b0110;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat_w;
  logic [N*SW-1:0]   m_sel;
  logic [DW-1:0]     m_dat_r;
  logic [N-1:0]      m_ack, m_err, grant;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_w;
  logic [SW-1:0]     s_sel;
  logic [DW-1:0]     s_dat_r = '0;
  logic              s_ack = 1'b0, s_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat_w (m_dat_w),
    .m_sel   (m_sel),
    .m_dat_r (m_dat_r),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_adr   (s_adr),
    .s_dat_w (s_dat_w),
    .s_sel   (s_sel),
    .s_dat_r (s_dat_r),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .grant   (grant)
  );

  typedef struct {
    logic       rst;
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic       err;
    logic       chk;
    logic [3:0] g;
    logic [3:0] ma;
    logic [3:0] me;
    logic       sc;
    logic       ss;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] adr_of(input int i);
    return 32'h1000_0000 + 32'(i * 256);
  endfunction

  function automatic logic [31:0] dat_of(input int i);
    return 32'hA0A0_0000 + 32'(i);
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    int r;
    r = 0;
    for (int k = 0; k < 4; k++) if (oh[k]) r = k;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] cyc, input logic [3:0] stb,
                     input logic ack, input logic err, input logic chk,
                     input logic [3:0] g, input logic [3:0] ma, input logic [3:0] me,
                     input logic sc, input logic ss);
    vec_t v;
    v = '{rst:r, cyc:cyc, stb:stb, ack:ack, err:err, chk:chk,
          g:g, ma:ma, me:me, sc:sc, ss:ss};
    tbl.push_back(v);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_adr[i*AW +: AW]   = adr_of(i);
      m_dat_w[i*DW +: DW] = dat_of(i);
      m_sel[i*SW +: SW]   = SW'(i + 1);
    end

    //  rst cyc      stb      ack  err  chk  grant    ack      err      scyc sstb
    add(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0001, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0001, 1, 0, 1, 4'b0001, 4'b0001, 4'b0000, 1, 1);
    add(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    // all four request together: 0,1,2,3,0 with no idle cycle
    add(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b1111, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b1111, 1, 0, 1, 4'b0001, 4'b0001, 4'b0000, 1, 1);
    add(0, 4'b1110, 4'b1110, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1110, 4'b1110, 1, 0, 1, 4'b0010, 4'b0010, 4'b0000, 1, 1);
    add(0, 4'b1100, 4'b1100, 0, 0, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1100, 4'b1100, 1, 0, 1, 4'b0100, 4'b0100, 4'b0000, 1, 1);
    add(0, 4'b1000, 4'b1000, 0, 0, 1, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1001, 4'b1001, 1, 0, 1, 4'b1000, 4'b1000, 4'b0000, 1, 1);
    add(0, 4'b0001, 4'b0001, 0, 0, 1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0001, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 1, 1);
    // owner drops cyc in the cycle its ack arrives
    add(0, 4'b0000, 4'b0000, 1, 0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 0);
    // master 2 owns while master 1 waits; hand-over 2 -> 1
    add(0, 4'b0100, 4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0110, 4'b0100, 0, 0, 1, 4'b0100, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b0110, 4'b0100, 1, 0, 1, 4'b0100, 4'b0100, 4'b0000, 1, 1);
    add(0, 4'b0010, 4'b0010, 0, 0, 1, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0010, 4'b0010, 1, 0, 1, 4'b0010, 4'b0010, 4'b0000, 1, 1);
    // stb low with cyc high keeps ownership against a waiting master
    add(0, 4'b0011, 4'b0000, 0, 0, 1, 4'b0010, 4'b0000, 4'b0000, 1, 0);
    // slave hangs: err on the 4th stalled cycle, stb forced low there
    add(0, 4'b0011, 4'b0010, 0, 0, 1, 4'b0010, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b0011, 4'b0010, 0, 0, 1, 4'b0010, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b0011, 4'b0010, 0, 0, 1, 4'b0010, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b0011, 4'b0010, 0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 1, 0);
    add(0, 4'b0011, 4'b0010, 0, 0, 1, 4'b0010, 4'b0000, 4'b0000, 1, 1);
    add(0, 4'b0001, 4'b0001, 0, 0, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    // slave err passed to the owner only
    add(0, 4'b0001, 4'b0001, 0, 1, 1, 4'b0001, 4'b0000, 4'b0001, 1, 1);
    add(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    foreach (tbl[i]) begin
      logic [31:0] rd;
      int          oi;
      @(negedge clk);
      rd      = (i == 3) ? 32'hDEADBEEF : 32'h5A5A_0000 + 32'(i);
      rst     = tbl[i].rst;
      m_cyc   = tbl[i].cyc;
      m_stb   = tbl[i].stb;
      s_ack   = tbl[i].ack;
      s_err   = tbl[i].err;
      s_dat_r = rd;
      #1;
      if (tbl[i].chk) begin
        oi = idx_of(tbl[i].g);
        check($sformatf("row%0d grant", i), 64'(grant), 64'(tbl[i].g));
        check($sformatf("row%0d m_ack", i), 64'(m_ack), 64'(tbl[i].ma));
        check($sformatf("row%0d m_err", i), 64'(m_err), 64'(tbl[i].me));
        check($sformatf("row%0d s_cyc", i), 64'(s_cyc), 64'(tbl[i].sc));
        check($sformatf("row%0d s_stb", i), 64'(s_stb), 64'(tbl[i].ss));
        check($sformatf("row%0d s_adr", i), 64'(s_adr),
              (tbl[i].g != 4'b0000) ? 64'(adr_of(oi)) : 64'd0);
        check($sformatf("row%0d s_we", i), 64'(s_we),
              (tbl[i].g != 4'b0000) ? 64'(m_we[oi]) : 64'd0);
        check($sformatf("row%0d m_dat_r", i), 64'(m_dat_r), 64'(rd));
      end
    end

    // ack racing the timeout on the 4th stalled cycle wins
    reset_dut();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    #1 check("race idle grant", 64'(grant), 64'd0);
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk);
      #1;
      check($sformatf("race stall%0d err", s), 64'(m_err), 64'd0);
      check($sformatf("race stall%0d stb", s), 64'(s_stb), 64'd1);
    end
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    check("race ack", 64'(m_ack), 64'b0001);
    check("race err", 64'(m_err), 64'd0);
    check("race stb", 64'(s_stb), 64'd1);
    @(negedge clk);
    s_ack = 1'b0;
    #1 check("race after err", 64'(m_err), 64'd0);

    // reset in the middle of a write by master 2
    reset_dut();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    @(negedge clk);
    #1;
    check("rstw grant", 64'(grant), 64'b0100);
    check("rstw s_we", 64'(s_we), 64'd1);
    check("rstw s_adr", 64'(s_adr), 64'(adr_of(2)));
    check("rstw s_dat_w", 64'(s_dat_w), 64'(dat_of(2)));
    check("rstw s_sel", 64'(s_sel), 64'd3);
    @(negedge clk);
    rst = 1'b1; m_cyc = 4'b1111; m_stb = 4'b1111;
    @(negedge clk);
    rst = 1'b0; s_ack = 1'b1;
    #1;
    check("rstw s_cyc", 64'(s_cyc), 64'd0);
    check("rstw grant0", 64'(grant), 64'd0);
    check("rstw m_ack", 64'(m_ack), 64'd0);
    check("rstw m_err", 64'(m_err), 64'd0);
    @(negedge clk);
    s_ack = 1'b0;
    #1 check("rstw first owner", 64'(grant), 64'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
